// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/CTRL register block in front of
// a byte FIFO feeding an 8N1 serial shifter.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALURes,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        tx
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q, en_q;
    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    logic [1:0] offset;
    logic       wr_txdata, wr_status, wr_ctrl;
    logic       full, empty, busy, pop, push_ok, ovf_set, baud_last;
    logic       unused_bits;

    assign unused_bits = ^{ALURes[1:0], WriteData[31:8]};

    assign Sel       = (ALURes[31:4] == BASE_ADDR[31:4]);
    assign offset    = ALURes[3:2];
    assign wr_txdata = Sel && MemWrite && (offset == 2'd0);
    assign wr_status = Sel && MemWrite && (offset == 2'd1);
    assign wr_ctrl   = Sel && MemWrite && (offset == 2'd2);

    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign busy      = (state_q != S_IDLE);
    assign pop       = (state_q == S_IDLE) && en_q && !empty;
    // A full FIFO still accepts a byte when the shifter drains one on the same edge.
    assign push_ok   = wr_txdata && (!full || pop);
    assign ovf_set   = wr_txdata && !push_ok;
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign tx        = tx_q;

    // Zero-latency load data for the core.
    always_comb begin
        ReadData = '0;
        if (Sel) begin
            case (offset)
                2'd1: begin
                    ReadData[0]      = full;
                    ReadData[1]      = empty;
                    ReadData[2]      = busy;
                    ReadData[3]      = ovf_q;
                    ReadData[8 +: CW] = count_q;
                end
                2'd2:    ReadData[0] = en_q;
                default: ReadData    = '0;
            endcase
        end
    end

    // FIFO storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            fifo_q[wr_ptr_q] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            en_q     <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (wr_status && WriteData[3]) begin
                ovf_q <= 1'b0;
            end
            if (wr_ctrl) en_q <= WriteData[0];
        end
    end

    // Serial framing FSM; tx is loaded with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        state_q <= S_START;
                        shift_q <= fifo_q[rd_ptr_q];
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_STOP: begin
                    tx_q <= 1'b1;
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed scenarios plus random register traffic,
// compared against a queue-based frame-timing model.
module tb_mmio_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALURes, WriteData, ReadData;
    logic        MemWrite, Sel, tx;

    always #5 clk = ~clk;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .ALURes(ALURes), .WriteData(WriteData),
        .MemWrite(MemWrite), .ReadData(ReadData), .Sel(Sel), .tx(tx)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_seen = 0;
    int falls[$];
    logic prev_tx = 1'b1;

    // Model: queued bytes, sticky flags, and the frame currently on the wire.
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_en  = 1'b1;
    bit         m_act = 1'b0;
    int         m_fcnt = 0;
    logic [7:0] m_byte = 8'h00;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[31:4] == BASE[31:4]) begin
            if (a[3:2] == 2'd1) begin
                r[0]     = (mq.size() == DEPTH);
                r[1]     = (mq.size() == 0);
                r[2]     = m_act;
                r[3]     = m_ovf;
                r[8 +: 4] = 4'(mq.size());
            end else if (a[3:2] == 2'd2) begin
                r[0] = m_en;
            end
        end
        return r;
    endfunction

    // Expected line level from the position inside a 10-bit frame.
    function automatic logic m_tx();
        if (!m_act)            return 1'b1;
        if (m_fcnt < CPB)      return 1'b0;
        if (m_fcnt < 9 * CPB)  return m_byte[(m_fcnt - CPB) / CPB];
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit full0, do_pop;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0; m_en = 1'b1; m_act = 1'b0; m_fcnt = 0;
            return;
        end
        full0  = (mq.size() == DEPTH);
        do_pop = !m_act && m_en && (mq.size() != 0);
        if (m_act) begin
            m_fcnt++;
            if (m_fcnt == 10 * CPB) m_act = 1'b0;
        end
        if (do_pop) begin
            m_byte = mq.pop_front();
            m_act  = 1'b1;
            m_fcnt = 0;
        end
        if (MemWrite && ALURes[31:4] == BASE[31:4]) begin
            case (ALURes[3:2])
                2'd0: if (!full0 || do_pop) mq.push_back(WriteData[7:0]); else m_ovf = 1'b1;
                2'd1: if (WriteData[3]) m_ovf = 1'b0;
                2'd2: m_en = WriteData[0];
                default: ;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        MemWrite = 1'b0;
        ALURes   = a;
        #1;
        check(tag, ReadData, exp);
    endtask

    // One clock: drive, advance model, then check line, status and a random probe.
    task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic we);
        logic [31:0] pa;
        ALURes = a; WriteData = wd; MemWrite = we;
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("tx", {31'b0, tx}, {31'b0, m_tx()});
        if (prev_tx && !tx) falls.push_back(cyc);
        prev_tx  = tx;
        MemWrite = 1'b0;
        ALURes   = BASE + 32'h4;
        #1;
        check("status", ReadData, m_read(ALURes));
        if (ReadData[2]) busy_seen++;
        pa = ($urandom_range(0, 4) == 4) ? 32'h0000_2000 : BASE + 32'(4 * $urandom_range(0, 3));
        pa[1:0] = 2'($urandom);
        ALURes = pa;
        #1;
        check("probe", ReadData, m_read(pa));
        check("sel", {31'b0, Sel}, {31'b0, pa[31:4] == BASE[31:4]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(BASE + 32'h4, 32'h0, 1'b0);
    endtask

    initial begin
        int t0;
        int r;
        logic [31:0] a;
        reset = 1'b1; ALURes = '0; WriteData = '0; MemWrite = 1'b0;
        cycle(BASE, 32'h0, 1'b0);
        cycle(BASE, 32'h0, 1'b0);
        reset = 1'b0;

        // Reset state
        peek("rst_status", BASE + 32'h4, 32'h0000_0002);
        peek("rst_ctrl", BASE + 32'h8, 32'h0000_0001);
        check("rst_tx", {31'b0, tx}, 32'h1);

        // Single byte 0x55: start edge one cycle after the write, 160 busy cycles
        falls.delete(); busy_seen = 0;
        cycle(BASE, 32'h55, 1'b1);
        t0 = cyc;
        idle(175);
        check("b55_falls", 32'(falls.size()), 32'd5);
        check("b55_first", 32'(falls[0]), 32'(t0 + 1));
        check("b55_busy", 32'(busy_seen), 32'd160);

        // Back-to-back bytes: 161-cycle start spacing
        falls.delete();
        cycle(BASE, 32'hA5, 1'b1);
        cycle(BASE, 32'h3C, 1'b1);
        idle(340);
        check("b2b_spacing", 32'(falls[$size(falls) == 0 ? 0 : 0]), 32'(falls[0]));
        r = 0;
        for (int i = 1; i < falls.size(); i++)
            if (falls[i] - falls[0] == 10 * CPB + 1) r = 1;
        check("b2b_161", 32'(r), 32'd1);

        // Overflow while disabled, then clear it
        cycle(BASE + 32'h8, 32'h0, 1'b1);
        for (int i = 0; i < 9; i++) cycle(BASE, 32'($urandom_range(0, 255)), 1'b1);
        peek("ovf_status", BASE + 32'h4, m_read(BASE + 32'h4));
        check("ovf_bits", ReadData & 32'hF09, 32'h0000_0809);
        cycle(BASE + 32'h4, 32'h8, 1'b1);
        peek("ovf_clear", BASE + 32'h4, 32'h0000_0801);

        // Enable, then disable mid-frame: current frame completes, nothing else pops
        cycle(BASE + 32'h8, 32'h1, 1'b1);
        idle(50);
        cycle(BASE + 32'h8, 32'h0, 1'b1);
        idle(200);
        peek("dis_status", BASE + 32'h4, 32'h0000_0700);

        // Reset 40 cycles into a frame, with a simultaneous write
        cycle(BASE + 32'h8, 32'h1, 1'b1);
        idle(40);
        falls.delete();
        reset = 1'b1;
        cycle(BASE, 32'h77, 1'b1);
        reset = 1'b0;
        check("rst_mid_tx", {31'b0, tx}, 32'h1);
        peek("rst_mid_status", BASE + 32'h4, 32'h0000_0002);
        idle(200);
        check("rst_mid_nofall", 32'(falls.size()), 32'd0);

        // Foreign address and offset 3 have no effect
        cycle(BASE + 32'h8, 32'h0, 1'b1);
        cycle(BASE, 32'h11, 1'b1);
        cycle(32'h0000_2000, 32'hFF, 1'b1);
        peek("far_rd", 32'h0000_2000, 32'h0);
        check("far_sel", {31'b0, Sel}, 32'h0);
        cycle(BASE + 32'hC, 32'hFFFF_FFFF, 1'b1);
        peek("off3_rd", BASE + 32'hC, 32'h0);
        peek("txdata_rd", BASE, 32'h0);
        peek("far_status", BASE + 32'h4, 32'h0000_0100);

        // Random register traffic
        cycle(BASE + 32'h8, 32'h1, 1'b1);
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 199);
            if (r < 6) begin
                a = BASE; a[1:0] = 2'($urandom);
                cycle(a, $urandom, 1'b1);
            end else if (r == 6) begin
                cycle(BASE + 32'h4, $urandom, 1'b1);
            end else if (r == 7) begin
                cycle(BASE + 32'h8, {$urandom_range(0, 3) != 0 ? 32'h1 : 32'h0}, 1'b1);
            end else if (r == 8) begin
                cycle(BASE + 32'hC, $urandom, 1'b1);
            end else if (r == 9) begin
                cycle(32'h0000_2000 + 32'($urandom_range(0, 15)), $urandom, 1'b1);
            end else begin
                cycle(BASE + 32'h4, 32'h0, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
